// File: rtl/pc_fetch_if.sv
// Fetch-stage bus between the fetch controller, the PC register, imem and the hazard/redirect sources.
interface pc_fetch_if;
    logic [29:0] pc;
    logic        imem_ready;
    logic        load_use;
    logic        br_taken;
    logic        jump;
    logic [29:0] target;
    logic        exc_req;
    logic        eret;
    logic [29:0] epc;

    logic        pc_wr;
    logic [29:0] npc;
    logic        imem_req;
    logic        ifid_wr;
    logic        ifid_flush;
    logic        fetch_err;

    modport master (
        output pc, imem_ready, load_use, br_taken, jump, target, exc_req, eret, epc,
        input  pc_wr, npc, imem_req, ifid_wr, ifid_flush, fetch_err
    );

    modport slave (
        input  pc, imem_ready, load_use, br_taken, jump, target, exc_req, eret, epc,
        output pc_wr, npc, imem_req, ifid_wr, ifid_flush, fetch_err
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: sequences PC and IF/ID latch, arbitrates redirects/stalls and
// tolerates variable imem latency with a timeout that vectors to the exception handler.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic        clk,
    input logic        rst,
    pc_fetch_if.slave  bus
);
    localparam int unsigned PCW = 30;
    localparam int unsigned CW  = 8;
    localparam logic [PCW-1:0] RESET_WA = RESET_PC[31:2];
    localparam logic [PCW-1:0] EXC_WA   = EXC_VEC[31:2];

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_t;

    state_t         r_state, w_state_nx;
    logic           r_pend_v, w_pend_v_nx;
    logic [PCW-1:0] r_pend_pc, w_pend_pc_nx;
    logic [1:0]     r_pend_pri, w_pend_pri_nx;
    logic [CW-1:0]  r_wait_cnt, w_wait_cnt_nx;

    logic [1:0]     w_pri;
    logic [PCW-1:0] w_tgt;
    logic           w_take_new;
    logic           w_have_redir;
    logic [PCW-1:0] w_redir_pc;

    logic           w_pc_wr, w_imem_req, w_ifid_wr, w_ifid_flush, w_fetch_err;
    logic [PCW-1:0] w_npc;

    // Redirect priority: exception 3, eret 2, branch/jump 1, none 0.
    always_comb begin
        w_pri = 2'd0;
        w_tgt = bus.target;
        if (bus.exc_req) begin
            w_pri = 2'd3;
            w_tgt = EXC_WA;
        end else if (bus.eret) begin
            w_pri = 2'd2;
            w_tgt = bus.epc;
        end else if (bus.br_taken || bus.jump) begin
            w_pri = 2'd1;
        end
    end

    // A present redirect displaces a latched one unless the latched one outranks it.
    assign w_take_new   = (w_pri != 2'd0) && (!r_pend_v || (w_pri >= r_pend_pri));
    assign w_have_redir = w_take_new || r_pend_v;
    assign w_redir_pc   = w_take_new ? w_tgt : r_pend_pc;

    always_comb begin
        w_state_nx    = r_state;
        w_pend_v_nx   = r_pend_v;
        w_pend_pc_nx  = r_pend_pc;
        w_pend_pri_nx = r_pend_pri;
        w_wait_cnt_nx = r_wait_cnt;
        w_pc_wr       = 1'b0;
        w_npc         = bus.pc + PCW'(1);
        w_imem_req    = 1'b0;
        w_ifid_wr     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_fetch_err   = 1'b0;

        if (rst || (r_state == S_BOOT)) begin
            w_pc_wr      = 1'b1;
            w_npc        = RESET_WA;
            w_ifid_flush = 1'b1;
            w_state_nx   = S_FETCH;
        end else if ((r_state == S_FETCH) || (r_state == S_WAIT)) begin
            w_imem_req = 1'b1;
            if (bus.imem_ready) begin
                if (w_have_redir) begin
                    w_pc_wr      = 1'b1;
                    w_npc        = w_redir_pc;
                    w_ifid_flush = 1'b1;
                end else if (!bus.load_use) begin
                    w_pc_wr   = 1'b1;
                    w_ifid_wr = 1'b1;
                end
                w_pend_v_nx   = 1'b0;
                w_wait_cnt_nx = '0;
                w_state_nx    = S_FETCH;
            end else if ((r_state == S_WAIT) && (r_wait_cnt == CW'(MAX_WAIT))) begin
                // Timeout drops any pending redirect and vectors to the handler.
                w_fetch_err   = 1'b1;
                w_pc_wr       = 1'b1;
                w_npc         = EXC_WA;
                w_ifid_flush  = 1'b1;
                w_pend_v_nx   = 1'b0;
                w_wait_cnt_nx = '0;
                w_state_nx    = S_FETCH;
            end else begin
                w_wait_cnt_nx = (r_state == S_FETCH) ? CW'(1) : r_wait_cnt + CW'(1);
                w_state_nx    = S_WAIT;
                if (w_take_new) begin
                    w_pend_v_nx   = 1'b1;
                    w_pend_pc_nx  = w_tgt;
                    w_pend_pri_nx = w_pri;
                end
            end
        end else begin
            w_state_nx = S_BOOT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= '0;
            r_pend_pri <= 2'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_pend_v   <= w_pend_v_nx;
            r_pend_pc  <= w_pend_pc_nx;
            r_pend_pri <= w_pend_pri_nx;
            r_wait_cnt <= w_wait_cnt_nx;
        end
    end

    assign bus.pc_wr      = w_pc_wr;
    assign bus.npc        = w_npc;
    assign bus.imem_req   = w_imem_req;
    assign bus.ifid_wr    = w_ifid_wr;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.fetch_err  = w_fetch_err;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios then randomized traffic,
// expected outputs from a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;
    localparam logic [29:0] RESET_WA = 30'h0000_0C00;
    localparam logic [29:0] EXC_WA   = 30'h0000_1060;
    localparam int          MAX_WAIT = 8;

    typedef struct {
        bit          rst, rdy, lu, br, jp, exc, er;
        logic [29:0] tgt, epc;
    } stim_t;

    typedef struct packed {
        logic        pc_wr;
        logic [29:0] npc;
        logic        imem_req;
        logic        ifid_wr;
        logic        ifid_flush;
        logic        fetch_err;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    pc_fetch_if bus();

    pc_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    out_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cycle  = 0;

    // Model state: booting, waiting on imem, cycles waited, latched redirect.
    bit          m_boot = 1'b1;
    bit          m_wait = 1'b0;
    int          m_cnt  = 0;
    bit          m_pend = 1'b0;
    logic [29:0] m_pend_tgt = '0;
    int          m_pend_pri = 0;
    logic [29:0] m_pc = '0;

    function automatic stim_t mk(bit r, bit rdy, bit lu, bit br, bit jp, logic [29:0] tgt,
                                 bit exc, bit er, logic [29:0] epc);
        stim_t s;
        s.rst = r; s.rdy = rdy; s.lu = lu; s.br = br; s.jp = jp;
        s.tgt = tgt; s.exc = exc; s.er = er; s.epc = epc;
        return s;
    endfunction

    task automatic model(input stim_t s, input logic [29:0] pc, output out_t e);
        int          pri;
        logic [29:0] tgt;
        bit          have;
        logic [29:0] rpc;
        e.pc_wr = 1'b0; e.npc = pc + 30'd1; e.imem_req = 1'b1;
        e.ifid_wr = 1'b0; e.ifid_flush = 1'b0; e.fetch_err = 1'b0;
        if (s.rst || m_boot) begin
            e.pc_wr = 1'b1; e.npc = RESET_WA; e.imem_req = 1'b0; e.ifid_flush = 1'b1;
            m_boot = s.rst; m_wait = 1'b0; m_pend = 1'b0; m_cnt = 0;
            return;
        end
        pri = s.exc ? 3 : s.er ? 2 : (s.br || s.jp) ? 1 : 0;
        tgt = s.exc ? EXC_WA : s.er ? s.epc : s.tgt;
        have = 1'b0; rpc = '0;
        if (pri > 0 && (!m_pend || pri >= m_pend_pri)) begin
            have = 1'b1; rpc = tgt;
        end else if (m_pend) begin
            have = 1'b1; rpc = m_pend_tgt;
        end
        if (s.rdy) begin
            if (have) begin
                e.pc_wr = 1'b1; e.npc = rpc; e.ifid_flush = 1'b1;
            end else if (!s.lu) begin
                e.pc_wr = 1'b1; e.ifid_wr = 1'b1;
            end
            m_pend = 1'b0; m_wait = 1'b0; m_cnt = 0;
        end else if (m_wait && m_cnt == MAX_WAIT) begin
            e.fetch_err = 1'b1; e.pc_wr = 1'b1; e.npc = EXC_WA; e.ifid_flush = 1'b1;
            m_pend = 1'b0; m_wait = 1'b0; m_cnt = 0;
        end else begin
            m_cnt = m_wait ? m_cnt + 1 : 1;
            m_wait = 1'b1;
            if (pri > 0 && (!m_pend || pri >= m_pend_pri)) begin
                m_pend = 1'b1; m_pend_tgt = tgt; m_pend_pri = pri;
            end
        end
    endtask

    // Drive one cycle of stimulus just after the edge and queue its expected outputs.
    task automatic step(input stim_t s);
        out_t e;
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.imem_ready = s.rdy;
        bus.load_use   = s.lu;
        bus.br_taken   = s.br;
        bus.jump       = s.jp;
        bus.target     = s.tgt;
        bus.exc_req    = s.exc;
        bus.eret       = s.er;
        bus.epc        = s.epc;
        bus.pc         = m_pc;
        model(s, m_pc, e);
        sb_q.push_back(e);
        if (e.pc_wr) m_pc = e.npc;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 1, 0, 0, 0, '0, 0, 0, '0));
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the oldest queued expectation.
    initial begin
        out_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a.pc_wr = bus.pc_wr; a.npc = bus.npc; a.imem_req = bus.imem_req;
                a.ifid_wr = bus.ifid_wr; a.ifid_flush = bus.ifid_flush; a.fetch_err = bus.fetch_err;
                n_checks++;
                n_cycle++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got pc_wr=%b npc=%h req=%b ifid_wr=%b flush=%b err=%b; expected pc_wr=%b npc=%h req=%b ifid_wr=%b flush=%b err=%b",
                             n_cycle, a.pc_wr, a.npc, a.imem_req, a.ifid_wr, a.ifid_flush, a.fetch_err,
                             e.pc_wr, e.npc, e.imem_req, e.ifid_wr, e.ifid_flush, e.fetch_err);
                end
            end
        end
    end

    initial begin
        int stall_left;
        stim_t s;
        rst = 1'b1;
        bus.imem_ready = 1'b1; bus.load_use = 1'b0; bus.br_taken = 1'b0; bus.jump = 1'b0;
        bus.target = '0; bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = '0; bus.pc = '0;

        // Reset, boot, five sequential fetches up to pc=0x0C05.
        step(mk(1, 1, 0, 0, 0, '0, 0, 0, '0));
        step(mk(1, 1, 0, 0, 0, '0, 0, 0, '0));
        seq(6);
        // Load-use hold, then resume.
        step(mk(0, 1, 1, 0, 0, '0, 0, 0, '0));
        seq(2);
        // Branch latched while imem stalls, applied on ready.
        step(mk(0, 0, 0, 1, 0, 30'h0D00, 0, 0, '0));
        step(mk(0, 0, 0, 0, 0, '0, 0, 0, '0));
        step(mk(0, 0, 0, 0, 0, '0, 0, 0, '0));
        step(mk(0, 1, 0, 0, 0, '0, 0, 0, '0));
        seq(2);
        // Exception beats branch and load-use.
        step(mk(0, 1, 1, 1, 0, 30'h0D00, 1, 0, '0));
        seq(1);
        // Timeout: one FETCH stall cycle plus MAX_WAIT wait cycles.
        for (int i = 0; i < MAX_WAIT + 1; i++) step(mk(0, 0, 0, 0, 0, '0, 0, 0, '0));
        seq(2);
        // Lower-priority branch must not displace a latched eret.
        step(mk(0, 0, 0, 0, 0, '0, 0, 1, 30'h0123));
        step(mk(0, 0, 0, 1, 0, 30'h0D00, 0, 0, '0));
        step(mk(0, 1, 0, 0, 0, '0, 0, 0, '0));
        // ERET to the top of the address space, then wrap.
        step(mk(0, 1, 0, 0, 0, '0, 0, 1, 30'h3FFF_FFFF));
        seq(2);
        // Reset while waiting with a pending jump.
        step(mk(0, 0, 0, 0, 1, 30'h0777, 0, 0, '0));
        step(mk(0, 0, 0, 0, 0, '0, 0, 0, '0));
        step(mk(1, 0, 0, 0, 0, '0, 0, 0, '0));
        seq(3);

        // Randomized traffic with occasional long imem stalls and rare resets.
        stall_left = 0;
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            if (stall_left > 0) begin
                s.rdy = 1'b0;
                stall_left--;
            end else begin
                s.rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) stall_left = $urandom_range(5, 12);
            end
            s.lu  = ($urandom_range(0, 5) == 0);
            s.br  = ($urandom_range(0, 9) == 0);
            s.jp  = ($urandom_range(0, 14) == 0);
            s.exc = ($urandom_range(0, 29) == 0);
            s.er  = ($urandom_range(0, 29) == 0);
            s.tgt = 30'($urandom);
            s.epc = 30'($urandom);
            step(s);
        end

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage controller that sequences the PC register and the IF/ID latch in the pipelined MIPS core. It generates the PC write enable and next-PC value, and arbitrates between exception entry, ERET, branch/jump redirect, load-use stall and sequential fetch. It also handles a variable-latency instruction-memory handshake, with a timeout.

Parameters:
RESET_PC, 32'h0000_3000, byte address loaded into the PC at reset (word address = RESET_PC[31:2])
EXC_VEC, 32'h0000_4180, byte address of the exception handler
MAX_WAIT, 8, maximum imem wait cycles before a fetch error (range 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pc  in  30  current PC[31:2] from the PC register
imem_ready  in  1  instruction memory returns the instruction this cycle
load_use  in  1  load-use hazard from decode
br_taken  in  1  branch resolved taken
jump  in  1  jump/jal/jr redirect
target  in  30  branch/jump target [31:2]
exc_req  in  1  exception request from later stages
eret  in  1  return from exception
epc  in  30  EPC[31:2]
pc_wr  out  1  PC write enable
npc  out  30  next PC [31:2]
imem_req  out  1  fetch request
ifid_wr  out  1  IF/ID latch write enable
ifid_flush  out  1  IF/ID latch clear (bubble)
fetch_err  out  1  one-cycle pulse on imem timeout

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- States: BOOT, FETCH, WAIT.
- Registers: state, pend_v, pend_pc[31:2], wait_cnt[7:0].
- Reset (rst=1 at an edge): state=BOOT, pend_v=0, wait_cnt=0.
- Outputs while in BOOT or held in reset:
  - pc_wr=1, npc=RESET_PC[31:2]
  - imem_req=0, ifid_wr=0, ifid_flush=1, fetch_err=0
- BOOT -> FETCH unconditionally on the next cycle.
- Redirect source priority, evaluated every cycle:
  - exc_req: target EXC_VEC
  - eret: target epc
  - br_taken|jump: target = target input
  - none of these: no redirect
- FETCH, imem_req=1:
  - imem_ready=1 and redirect pending (pend_v) or present: pc_wr=1, npc = pend_pc if pend_v else redirect target; ifid_flush=1, ifid_wr=0; clear pend_v. Stay in FETCH.
  - imem_ready=1, no redirect, load_use=1: pc_wr=0, ifid_wr=0, ifid_flush=0 (hold). Stay in FETCH.
  - imem_ready=1, no redirect, no load_use: pc_wr=1, npc=pc+1 (30-bit wrap, 30'h3FFF_FFFF -> 0), ifid_wr=1. Stay in FETCH.
  - imem_ready=0: pc_wr=0, ifid_wr=0. If a redirect is present, latch it into pend_v/pend_pc. wait_cnt=1, go to WAIT.
- WAIT, imem_req=1, pc_wr=0 unless leaving:
  - A new redirect overwrites pend_pc only if its priority is >= the latched one. Exception always wins.
  - imem_ready=1: same actions as the FETCH/imem_ready=1 cases. The returning instruction is discarded (flush) if pend_v or a redirect is present. wait_cnt=0, go to FETCH.
  - imem_ready=0 and wait_cnt==MAX_WAIT: fetch_err=1, pc_wr=1, npc=EXC_VEC, ifid_flush=1, pend_v=0, wait_cnt=0, go to FETCH.
  - otherwise: wait_cnt++.
- pc_wr and ifid_flush are never asserted for a redirect without its target on npc in the same cycle.
- npc is don't-care when pc_wr=0; drive pc+1.
- rst asserted mid-WAIT: abandon the pending fetch and redirect, go to BOOT, write RESET_PC.
- exc_req and load_use together: exception wins, no stall.
- Latency:
  - Redirect applied in the same cycle as imem_ready.
  - PC updated at the following edge.
  - One bubble per redirect.

Test Plan:
- Reset: rst=1 for 2 cycles then 0, imem_ready=1 -> pc_wr=1, npc=30'h0C00 during reset. BOOT one cycle, then sequential npc=pc+1 each cycle, ifid_wr=1.
- Load-use: in FETCH, pc=30'h0C05, load_use=1 for 1 cycle -> pc_wr=0, ifid_wr=0 that cycle. Next cycle npc=30'h0C06.
- Branch during wait: imem_ready=0 for 3 cycles, br_taken=1 with target=30'h0D00 in cycle 1 only. On ready -> pc_wr=1, npc=30'h0D00, ifid_flush=1.
- Priority: exc_req=1, br_taken=1 (target 30'h0D00), load_use=1 together with imem_ready=1 -> npc=30'h1060 (EXC_VEC), flush.
- Timeout: imem_ready held 0 with MAX_WAIT=8. After 8 WAIT cycles -> fetch_err pulses 1 cycle, npc=30'h1060, state FETCH.
- ERET/wrap: eret=1, epc=30'h3FFF_FFFF, ready -> npc=30'h3FFF_FFFF. Next sequential fetch gives npc=30'h0000_0000.
